// File: rtl/count_display_mux.sv
// Four-digit common-anode hex display scanner for a 16-bit count.
// The count is captured once per frame so a scan never mixes two values.
module count_display_mux #(
    parameter int PRESCALE = 4,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] count_in,
    input  logic        freeze,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p_reg;
    logic [1:0]    d_reg;
    logic [15:0]   snap_reg;
    logic          frame_done_reg;

    logic [3:0] nib_arr [4];
    logic [3:0] zero_above;
    logic [3:0] nib;
    logic       blank;
    logic       lit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg          <= '0;
            d_reg          <= 2'd0;
            snap_reg       <= 16'h0000;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (p_reg == P_LAST) begin
                p_reg <= '0;
                d_reg <= d_reg + 2'd1;
                // Last slot of digit 3 closes the frame: reload the snapshot.
                if (d_reg == 2'd3) begin
                    frame_done_reg <= 1'b1;
                    if (!freeze) begin
                        snap_reg <= count_in;
                    end
                end
            end else begin
                p_reg <= p_reg + PW'(1);
            end
        end
    end

    // zero_above[k] means digit k and everything more significant is zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign nib_arr[gi]    = snap_reg[4*gi +: 4];
            assign zero_above[gi] = (snap_reg[15:4*gi] == '0);
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        nib   = nib_arr[d_reg];
        blank = LZ_BLANK && (d_reg != 2'd0) && zero_above[d_reg];
        // Slot's first cycle is dark so the anode switch never ghosts.
        lit   = (p_reg != '0) && !blank;
        an_n  = lit ? ~(4'b0001 << d_reg) : 4'b1111;
        seg_n = lit ? hex7(nib) : 7'h7F;
    end

    assign dp_n       = 1'b1;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_count_display_mux.sv
// Directed bench for count_display_mux: one blanking and one non-blanking
// instance share stimulus; each frame is checked cycle by cycle.
module tb_count_display_mux;

    logic        clk;
    logic        reset;
    logic [15:0] count_in;
    logic        freeze;
    logic [3:0]  an_n_a, an_n_b;
    logic [6:0]  seg_n_a, seg_n_b;
    logic        dp_n_a, dp_n_b;
    logic        frame_done_a, frame_done_b;

    int checks;
    int failures;

    count_display_mux #(.PRESCALE(4), .LZ_BLANK(1'b1)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .freeze     (freeze),
        .an_n       (an_n_a),
        .seg_n      (seg_n_a),
        .dp_n       (dp_n_a),
        .frame_done (frame_done_a)
    );

    count_display_mux #(.PRESCALE(4), .LZ_BLANK(1'b0)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .freeze     (freeze),
        .an_n       (an_n_b),
        .seg_n      (seg_n_b),
        .dp_n       (dp_n_b),
        .frame_done (frame_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of the frame's first cycle (d=0,p=0); leaves at
    // the negedge of the next frame's first cycle. 7F in an expectation = blank.
    task automatic check_frame(input string tag, input logic fd,
                               input logic [6:0] a3, input logic [6:0] a2,
                               input logic [6:0] a1, input logic [6:0] a0,
                               input logic [6:0] b3, input logic [6:0] b2,
                               input logic [6:0] b1, input logic [6:0] b0);
        logic [6:0] ea [4];
        logic [6:0] eb [4];
        logic [3:0] an_a_x, an_b_x;
        logic [6:0] seg_a_x, seg_b_x;
        string t;
        ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
        eb[0] = b0; eb[1] = b1; eb[2] = b2; eb[3] = b3;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 4; p++) begin
                t = $sformatf("%s d%0d p%0d", tag, d, p);
                if (p == 0) begin
                    an_a_x = 4'b1111; seg_a_x = 7'h7F;
                    an_b_x = 4'b1111; seg_b_x = 7'h7F;
                end else begin
                    seg_a_x = ea[d];
                    seg_b_x = eb[d];
                    an_a_x  = (ea[d] == 7'h7F) ? 4'b1111 : ~(4'b0001 << d);
                    an_b_x  = (eb[d] == 7'h7F) ? 4'b1111 : ~(4'b0001 << d);
                end
                check_eq({t, " an_a"},  {12'h0, an_n_a},  {12'h0, an_a_x});
                check_eq({t, " seg_a"}, {9'h0, seg_n_a},  {9'h0, seg_a_x});
                check_eq({t, " an_b"},  {12'h0, an_n_b},  {12'h0, an_b_x});
                check_eq({t, " seg_b"}, {9'h0, seg_n_b},  {9'h0, seg_b_x});
                check_eq({t, " fd_a"},  {15'h0, frame_done_a},
                         {15'h0, (d == 0 && p == 0) ? fd : 1'b0});
                check_eq({t, " dp_a"},  {15'h0, dp_n_a}, 16'h0001);
                @(negedge clk);
            end
        end
        $display("frame %s checked (count_in=%h freeze=%b)", tag, count_in, freeze);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        count_in = 16'h1234;
        freeze   = 1'b0;

        // Reset held for 20 ns: outputs dark.
        @(negedge clk);
        check_eq("rst an_n",  {12'h0, an_n_a},  16'h000F);
        check_eq("rst seg_n", {9'h0, seg_n_a},  16'h007F);
        check_eq("rst dp_n",  {15'h0, dp_n_a},  16'h0001);
        check_eq("rst fd",    {15'h0, frame_done_a}, 16'h0000);
        @(posedge clk);
        #1;
        check_eq("rst hold an_n", {12'h0, an_n_a}, 16'h000F);
        check_eq("rst hold fd",   {15'h0, frame_done_a}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Frame 1 shows snap=0; frame 2 shows 0x1234.
        check_frame("f1_zero", 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        count_in = 16'h0005;
        check_frame("f2_1234", 1'b1, 7'h79, 7'h24, 7'h30, 7'h19, 7'h79, 7'h24, 7'h30, 7'h19);
        count_in = 16'h00A0;
        check_frame("f3_0005", 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40, 7'h40, 7'h40, 7'h12);

        // Freeze across three frame boundaries while count_in keeps changing.
        freeze = 1'b1; count_in = 16'h1111;
        check_frame("f4_00A0", 1'b1, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40);
        count_in = 16'h2222;
        check_frame("f5_frz",  1'b1, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40);
        count_in = 16'h3333;
        check_frame("f6_frz",  1'b1, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40);
        freeze = 1'b0; count_in = 16'hFFFF;
        check_frame("f7_frz",  1'b1, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40);
        count_in = 16'h0000;
        check_frame("f8_FFFF", 1'b1, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E);
        count_in = 16'h1234;
        check_frame("f9_0000", 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);

        // Frame 10 shows 0x1234; reset lands at d=2, p=2 (10 cycles in).
        check_eq("f10 fd", {15'h0, frame_done_a}, 16'h0001);
        repeat (10) @(negedge clk);
        check_eq("pre-rst seg_n", {9'h0, seg_n_a}, 16'h0024);
        check_eq("pre-rst an_n",  {12'h0, an_n_a}, 16'h000B);
        reset = 1'b1;
        #1;
        check_eq("mid-rst an_n",  {12'h0, an_n_a},  16'h000F);
        check_eq("mid-rst seg_n", {9'h0, seg_n_a},  16'h007F);
        check_eq("mid-rst fd",    {15'h0, frame_done_a}, 16'h0000);
        $display("reset asserted mid-frame at d=2 p=2");
        @(negedge clk);
        reset = 1'b0;
        check_frame("r1_zero", 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        check_frame("r2_1234", 1'b1, 7'h79, 7'h24, 7'h30, 7'h19, 7'h79, 7'h24, 7'h30, 7'h19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
